// File: rtl/pipe_pkg.sv
// Shared pipeline types: control bundle layout, NOP bundle, ALUOp encodings, widths.
package pipe_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int REG_AW_DEF  = 5;
  localparam int ALUOP_W_DEF = 2;

  typedef enum logic [ALUOP_W_DEF-1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_RTYPE = 2'd2,
    ALU_LOGIC = 2'd3
  } aluop_e;

  // Single-bit decoded controls, MSB first; ALUOp rides alongside so its width stays a parameter.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic reg_dst;
    logic branch;
  } ctrl_t;

  localparam int    CTRL_W   = $bits(ctrl_t);
  localparam ctrl_t CTRL_NOP = '0;

  typedef enum logic [1:0] {
    SEL_LOAD = 2'd0,
    SEL_NOP  = 2'd1,
    SEL_KEEP = 2'd2
  } idex_sel_e;

endpackage

// File: rtl/idex_bubble_ctrl.sv
// ID/EX bubble counter and flush/hold/bubble/load priority decode.
// IDEX_PERF_CNT_EN adds a saturating count of bubble-inserted NOPs.
module idex_bubble_ctrl
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] bubble,
  input  logic       flush,
  input  logic       hold,
  output idex_sel_e  sel,
  output logic       bubbling
`ifdef IDEX_PERF_CNT_EN
  , output logic [31:0] bubble_total
`endif
);

  logic [1:0] cnt, cnt_nxt, peak;

  always_comb begin
    sel     = SEL_LOAD;
    cnt_nxt = cnt;
    peak    = (bubble > cnt) ? bubble : cnt;
    if (flush) begin
      sel     = SEL_NOP;
      cnt_nxt = '0;
    end else if (hold) begin
      sel     = SEL_KEEP;
    end else if (peak != 2'd0) begin
      // peak >= 1 here, so the decrement cannot wrap
      sel     = SEL_NOP;
      cnt_nxt = peak - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

  assign bubbling = |cnt;

`ifdef IDEX_PERF_CNT_EN
  logic bub_nop;
  assign bub_nop = (sel == SEL_NOP) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   bubble_total <= '0;
    else if (bub_nop && bubble_total != '1)       bubble_total <= bubble_total + 32'd1;
  end
`endif

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: data flops steered by idex_bubble_ctrl (load / NOP / keep).
// IDEX_PERF_CNT_EN exposes bubble_total.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int ALUOP_W = ALUOP_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         bubble,
  input  logic               flush,
  input  logic               hold,
  input  logic               valid_ID,
  input  logic               RegWrite_ID,
  input  logic               MemRead_ID,
  input  logic               MemWrite_ID,
  input  logic               MemtoReg_ID,
  input  logic               ALUSrc_ID,
  input  logic               RegDst_ID,
  input  logic               Branch_ID,
  input  logic [ALUOP_W-1:0] ALUOp_ID,
  input  logic [DATA_W-1:0]  pc4_ID,
  input  logic [DATA_W-1:0]  rs_data_ID,
  input  logic [DATA_W-1:0]  rt_data_ID,
  input  logic [DATA_W-1:0]  imm_ID,
  input  logic [REG_AW-1:0]  rs_ID,
  input  logic [REG_AW-1:0]  rt_ID,
  input  logic [REG_AW-1:0]  rd_ID,
  output logic               valid_EX,
  output logic               RegWrite_EX,
  output logic               MemRead_EX,
  output logic               MemWrite_EX,
  output logic               MemtoReg_EX,
  output logic               ALUSrc_EX,
  output logic               RegDst_EX,
  output logic               Branch_EX,
  output logic [ALUOP_W-1:0] ALUOp_EX,
  output logic [DATA_W-1:0]  pc4_EX,
  output logic [DATA_W-1:0]  rs_data_EX,
  output logic [DATA_W-1:0]  rt_data_EX,
  output logic [DATA_W-1:0]  imm_EX,
  output logic [REG_AW-1:0]  rs_EX,
  output logic [REG_AW-1:0]  rt_EX,
  output logic [REG_AW-1:0]  rd_EX,
  output logic               bubbling
`ifdef IDEX_PERF_CNT_EN
  , output logic [31:0]      bubble_total
`endif
);

  idex_sel_e sel;
  ctrl_t     ctrl_id, ctrl_q;

  idex_bubble_ctrl u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble   (bubble),
    .flush    (flush),
    .hold     (hold),
    .sel      (sel),
    .bubbling (bubbling)
`ifdef IDEX_PERF_CNT_EN
    , .bubble_total (bubble_total)
`endif
  );

  assign ctrl_id = {RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID,
                    ALUSrc_ID, RegDst_ID, Branch_ID};

  // Invalid ID slots still carry data but never their controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_EX   <= 1'b0;
      ctrl_q     <= CTRL_NOP;
      ALUOp_EX   <= '0;
      pc4_EX     <= '0;
      rs_data_EX <= '0;
      rt_data_EX <= '0;
      imm_EX     <= '0;
      rs_EX      <= '0;
      rt_EX      <= '0;
      rd_EX      <= '0;
    end else begin
      case (sel)
        SEL_LOAD: begin
          valid_EX   <= valid_ID;
          ctrl_q     <= valid_ID ? ctrl_id : CTRL_NOP;
          ALUOp_EX   <= valid_ID ? ALUOp_ID : '0;
          pc4_EX     <= pc4_ID;
          rs_data_EX <= rs_data_ID;
          rt_data_EX <= rt_data_ID;
          imm_EX     <= imm_ID;
          rs_EX      <= rs_ID;
          rt_EX      <= rt_ID;
          rd_EX      <= rd_ID;
        end
        SEL_NOP: begin
          // rt_EX = 0 keeps the load-use compare from retriggering on a bubble
          valid_EX   <= 1'b0;
          ctrl_q     <= CTRL_NOP;
          ALUOp_EX   <= '0;
          pc4_EX     <= '0;
          rs_data_EX <= '0;
          rt_data_EX <= '0;
          imm_EX     <= '0;
          rs_EX      <= '0;
          rt_EX      <= '0;
          rd_EX      <= '0;
        end
        default: ;
      endcase
    end
  end

  assign RegWrite_EX = ctrl_q.reg_write;
  assign MemRead_EX  = ctrl_q.mem_read;
  assign MemWrite_EX = ctrl_q.mem_write;
  assign MemtoReg_EX = ctrl_q.mem_to_reg;
  assign ALUSrc_EX   = ctrl_q.alu_src;
  assign RegDst_EX   = ctrl_q.reg_dst;
  assign Branch_EX   = ctrl_q.branch;

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage pipeline CPU. Captures decoded control, operand data and register numbers from ID and presents them to EX.
- Sole consumer of the load-use unit's bubble/stall outputs. Inserts NOP bundles for the requested number of cycles.
- Supports flush on taken branch and a full hold from downstream.
- Produces MemRead_EX and rt_EX, which feed back to the load-use unit.

Parameters:
- DATA_W, 32, operand/immediate/PC width
- REG_AW, 5, register-number width
- ALUOP_W, 2, ALUOp field width

Ports:
- clk  in  1  pipeline clock; rising-edge
- rst_n  in  1  asynchronous active-low reset
- bubble  in  2  bubble cycles requested by load-use unit; 0 = none
- flush  in  1  taken branch/jump resolved; kill ID/EX contents
- hold  in  1  downstream freeze; keep all contents
- valid_ID  in  1  ID holds a real instruction
- RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, RegDst_ID, Branch_ID  in  1 each  decoded control
- ALUOp_ID  in  ALUOP_W  ALU operation class
- pc4_ID, rs_data_ID, rt_data_ID, imm_ID  in  DATA_W each  operands
- rs_ID, rt_ID, rd_ID  in  REG_AW each  register numbers
- *_EX outputs  out  same widths as each *_ID input above  registered copies
- valid_EX  out  1  EX holds a real instruction
- bubbling  out  1  high while bubble_cnt != 0

Behaviour:
- Reset (rst_n low, asynchronous): every output 0. A zero control bundle is the NOP. bubble_cnt = 0. Deassertion takes effect at the next rising edge.
- Latency: 1 cycle from ID inputs to EX outputs.
- Priority per rising edge: flush > hold > bubble insertion > normal load.
- Flush: load the NOP bundle with valid_EX=0, all data/register outputs 0, and bubble_cnt=0. A simultaneous bubble request is discarded.
- Hold:
  - All outputs and bubble_cnt are unchanged.
  - A bubble request arriving during hold is ignored. The load-use unit re-presents it, because its state is based on MemRead_EX, which is also frozen.
- Bubble insertion applies when bubble != 0 or bubble_cnt != 0:
  - Load the NOP bundle: all controls 0, valid_EX=0.
  - rt_EX is forced to 0 so the load-use comparison cannot re-trigger on a bubble. Other data outputs are 0.
  - Next bubble_cnt = max(bubble, bubble_cnt) - 1 (saturating at 0).
- Normal load: copy every *_ID input to *_EX; valid_EX = valid_ID.
- If valid_ID = 0 on a normal load, control outputs are forced to the NOP values. Data is still copied.
- bubbling = (bubble_cnt != 0). It is purely a function of the register.
- Boundary: bubble = 3 while bubble_cnt = 1 gives next bubble_cnt = 2 (max rule). bubble_cnt never wraps below 0.
- Reset mid-bubble clears bubble_cnt immediately; no residual NOPs.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- Defined:
  - Adds output bubble_total (32 bits), reset 0.
  - Increments on every edge where a NOP is inserted due to bubble insertion (not flush, not hold).
  - Saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package pipe_pkg:
  - ALUOP_W constant and ALUOp encodings (ADD=0, SUB=1, RTYPE=2, LOGIC=3).
  - Control-bundle field order/width constant and the NOP bundle constant.
  - REG_AW and DATA_W defaults.
- One sub-module, idex_bubble_ctrl:
  - Owns bubble_cnt, the max/decrement rule and the priority decode.
  - Outputs a 2-bit select: load / nop / keep.
- The top holds the data registers only.

Test Plan:
- Reset: rst_n=0 mid-cycle with valid contents → all outputs 0 immediately (asynchronous). bubble_cnt=0.
- Normal load: valid_ID=1, RegWrite_ID=1, rt_ID=5, imm_ID=0x10 → next edge RegWrite_EX=1, rt_EX=5, imm_EX=0x10, valid_EX=1.
- Load-use bubble: bubble=1 for one cycle with rt_ID=5 → one edge of NOP (MemRead_EX=0, rt_EX=0, valid_EX=0). The next edge loads ID normally. bubbling stays 0.
- Multi-bubble overlap: bubble=2, then bubble=3 one cycle later → bubble_cnt sequence 1,2,1,0; four NOP edges total. With IDEX_PERF_CNT_EN, bubble_total=4.
- Flush vs bubble: flush=1 and bubble=2 same edge → NOP, bubble_cnt=0. The next edge loads ID.
- Hold during bubble: bubble_cnt=1, hold=1 for 3 cycles → outputs frozen, bubble_cnt stays 1. After hold drops, one NOP is inserted, then normal load resumes.
